// File: rtl/nx_fifo_wr_packer_if.sv
// Bundle between the packer, its narrow beat source and the nx_fifo write port.
// The slave modport is the packer's view; master is the view of the surrounding logic.
interface nx_fifo_wr_packer_if #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 128
);
   localparam int RATIO = OUT_WIDTH / IN_WIDTH;
   localparam int LW    = $clog2(RATIO);
   localparam int FW    = OUT_WIDTH + LW + 1;

   logic                in_valid;
   logic                in_ready;
   logic [IN_WIDTH-1:0] in_data;
   logic                in_last;
   logic                fifo_full;
   logic                fifo_wen;
   logic [FW-1:0]       fifo_wdata;

   modport slave (
      input  in_valid, in_data, in_last, fifo_full,
      output in_ready, fifo_wen, fifo_wdata
   );

   modport master (
      output in_valid, in_data, in_last, fifo_full,
      input  in_ready, fifo_wen, fifo_wdata
   );
endinterface

// File: rtl/nx_fifo_wr_packer.sv
// Packs IN_WIDTH beats into OUT_WIDTH words with a {last, nlanes_m1} header and
// writes them to nx_fifo, holding off the beat stream while the FIFO is full.
module nx_fifo_wr_packer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   nx_fifo_wr_packer_if.slave       bus,
   output logic                     busy,
   output logic [15:0]              frame_cnt
);
   localparam int RATIO = OUT_WIDTH / IN_WIDTH;
   localparam int LW    = $clog2(RATIO);
   localparam int FW    = OUT_WIDTH + LW + 1;

   logic [OUT_WIDTH-1:0] acc;
   logic [OUT_WIDTH-1:0] merged;
   logic [LW-1:0]        lane;
   logic                 out_vld;
   logic [FW-1:0]        out_word;
   logic                 accept;
   logic                 complete;
   logic                 wen;

   // NOTE: every always_comb output gets a full default first, so no latch is inferred.
   always_comb begin
      merged = acc;
      merged[lane*IN_WIDTH +: IN_WIDTH] = bus.in_data;
   end

   // Backpressure only when the single output slot is occupied and cannot drain.
   assign bus.in_ready   = !(out_vld && bus.fifo_full);
   assign accept         = bus.in_valid && bus.in_ready;
   assign complete       = accept && ((lane == LW'(RATIO - 1)) || bus.in_last);
   assign wen            = out_vld && !bus.fifo_full && !clear && !rst;
   assign bus.fifo_wen   = wen;
   assign bus.fifo_wdata = out_word;
   assign busy           = out_vld || (lane != '0);

   // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         lane      <= '0;
         out_vld   <= 1'b0;
         out_word  <= '0;
         frame_cnt <= '0;
      end else if (clear) begin
         acc      <= '0;
         lane     <= '0;
         out_vld  <= 1'b0;
         out_word <= '0;
      end else begin
         if (wen && out_word[FW-1])
            frame_cnt <= frame_cnt + 16'd1;

         // A completing beat refills the slot even while it is being written out.
         if (complete) begin
            out_word <= {bus.in_last, lane, merged};
            acc      <= '0;
            lane     <= '0;
            out_vld  <= 1'b1;
         end else begin
            if (accept) begin
               acc  <= merged;
               lane <= lane + LW'(1);
            end
            if (wen)
               out_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_nx_fifo_wr_packer.sv
// Scoreboard bench for nx_fifo_wr_packer: a beat-level model pushes expected FIFO
// words, and a negedge monitor pops and compares each fifo_wen write.
module tb_nx_fifo_wr_packer;
   localparam int IW = 32;
   localparam int OW = 128;
   localparam int FW = 131;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        busy;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int wen_count = 0;
   int exp_frames = 0;

   logic [FW-1:0] exp_q[$];
   logic [OW-1:0] tb_acc;
   int            tb_lane;

   nx_fifo_wr_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

   nx_fifo_wr_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .bus       (bus),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Monitor: every FIFO write must match the oldest expected word.
   always @(negedge clk) begin
      if (bus.fifo_wen === 1'b1) begin
         logic [FW-1:0] exp_w;
         wen_count++;
         n_checks++;
         if (bus.fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL wen_while_full: fifo_wen=1 with fifo_full=%b", bus.fifo_full);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_wen: got wdata=%h, expected no write", bus.fifo_wdata);
         end else begin
            exp_w = exp_q.pop_front();
            if (exp_w[FW-1]) exp_frames++;
            if (bus.fifo_wdata !== exp_w) begin
               n_fail++;
               $display("FAIL wdata: got %h, expected %h", bus.fifo_wdata, exp_w);
            end
         end
      end
   end

   task automatic model_reset();
      tb_acc  = '0;
      tb_lane = 0;
   endtask

   task automatic model_beat(input logic [IW-1:0] d, input logic l);
      logic [OW-1:0] m;
      logic [1:0]    ln;
      m = tb_acc;
      m[tb_lane*IW +: IW] = d;
      ln = 2'(tb_lane);
      if (tb_lane == 3 || l) begin
         exp_q.push_back({l, ln, m});
         model_reset();
      end else begin
         tb_acc = m;
         tb_lane++;
      end
   endtask

   // Presents one beat starting just after a posedge; returns just after the accepting edge.
   task automatic send_beat(input logic [IW-1:0] d, input logic l, output bit stalled);
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      stalled = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!acc && tries < 200) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (!acc) stalled = 1'b1;
         tries++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL beat_timeout: beat %h not accepted in 200 cycles, expected acceptance", d);
      end else begin
         model_beat(d, l);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_frames(input string name);
      n_checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL %s: frame_cnt=%0d, expected %0d", name, frame_cnt, exp_frames);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.fifo_wen !== 1'b0 || bus.fifo_wdata !== '0 ||
          busy !== 1'b0 || frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL %s: in_ready=%b wen=%b wdata=%h busy=%b frame_cnt=%0d, expected 1 0 0 0 0",
                  name, bus.in_ready, bus.fifo_wen, bus.fifo_wdata, busy, frame_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
      bus.fifo_full = 1'b0;
      model_reset();
      idle(3);
      check_reset_outputs("reset_state");
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_full_word();
      bit s;
      logic [FW-1:0] t1_exp;
      t1_exp = {1'b1, 2'd3, 128'h00000044_00000033_00000022_00000011};
      send_beat(32'h11, 1'b0, s);
      send_beat(32'h22, 1'b0, s);
      send_beat(32'h33, 1'b0, s);
      send_beat(32'h44, 1'b1, s);
      @(negedge clk);
      n_checks++;
      if (bus.fifo_wen !== 1'b1 || bus.fifo_wdata !== t1_exp) begin
         n_fail++;
         $display("FAIL t1_word: wen=%b wdata=%h, expected wen=1 wdata=%h", bus.fifo_wen, bus.fifo_wdata, t1_exp);
      end
      @(posedge clk);
      #1;
      idle(1);
      check_frames("t1_frame_cnt");
   endtask

   task automatic test_partial();
      bit s;
      logic [FW-1:0] t2_exp;
      t2_exp = {1'b1, 2'd2, 32'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      send_beat(32'hAAAA_0001, 1'b0, s);
      send_beat(32'hBBBB_0002, 1'b0, s);
      send_beat(32'hCCCC_0003, 1'b1, s);
      @(negedge clk);
      n_checks++;
      if (bus.fifo_wen !== 1'b1 || bus.fifo_wdata !== t2_exp) begin
         n_fail++;
         $display("FAIL t2_word: wen=%b wdata=%h, expected wen=1 wdata=%h", bus.fifo_wen, bus.fifo_wdata, t2_exp);
      end
      @(posedge clk);
      #1;
      // Single-lane frames back to back: write and refill in the same cycle.
      for (int i = 0; i < 3; i++) send_beat(32'h5000_0000 + i, 1'b1, s);
      idle(2);
      check_frames("t2_frame_cnt");
   endtask

   task automatic test_full_stall();
      bit s;
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(32'h3000_0000 + i, 1'b0, s);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== 1'b0 || bus.fifo_wen !== 1'b0 || busy !== 1'b1 ||
             exp_q.size() != 1 || bus.fifo_wdata !== exp_q[0]) begin
            n_fail++;
            $display("FAIL t3_stall: in_ready=%b wen=%b busy=%b wdata=%h, expected 0 0 1 and held word",
                     bus.in_ready, bus.fifo_wen, busy, bus.fifo_wdata);
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.fifo_full = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.fifo_wen !== 1'b1 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL t3_release: wen=%b in_ready=%b, expected 1 1", bus.fifo_wen, bus.in_ready);
      end
      @(posedge clk);
      #1;
      send_beat(32'h3100_0000, 1'b0, s);
      n_checks++;
      if (s) begin
         n_fail++;
         $display("FAIL t3_resume: first beat stalled=1, expected 0");
      end
      send_beat(32'h3100_0001, 1'b1, s);
      idle(2);
      check_frames("t3_frame_cnt");
   endtask

   task automatic test_clear();
      bit s;
      // Pending word discarded by clear even though the FIFO frees up that same cycle.
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(32'h4000_0000 + i, 1'b0, s);
      void'(exp_q.pop_back());
      bus.fifo_full = 1'b0;
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      send_beat(32'h4100_0000, 1'b0, s);
      send_beat(32'h4100_0001, 1'b0, s);
      clear = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL t4_busy: busy=%b after clear, expected 0", busy);
      end
      @(posedge clk);
      #1;
      send_beat(32'h4200_0000, 1'b0, s);
      send_beat(32'h4200_0001, 1'b0, s);
      send_beat(32'h4200_0002, 1'b0, s);
      send_beat(32'h4200_0003, 1'b1, s);
      idle(2);
      check_frames("t4_frame_cnt_kept");
   endtask

   task automatic test_back_to_back();
      bit s;
      int stalls, wen0;
      time t0;
      stalls = 0;
      wen0 = wen_count;
      t0 = $time;
      for (int i = 0; i < 64; i++) begin
         send_beat($urandom, 1'b0, s);
         if (s) stalls++;
      end
      n_checks++;
      if (stalls != 0 || ($time - t0) != 64 * 10) begin
         n_fail++;
         $display("FAIL t5_throughput: stalls=%0d cycles=%0d, expected 0 and 64", stalls, ($time - t0) / 10);
      end
      idle(2);
      n_checks++;
      if (wen_count - wen0 != 16) begin
         n_fail++;
         $display("FAIL t5_wen_count: got %0d writes, expected 16", wen_count - wen0);
      end
      check_frames("t5_frame_cnt");
   endtask

   task automatic test_reset_mid();
      bit s;
      send_beat(32'h6000_0000, 1'b0, s);
      send_beat(32'h6000_0001, 1'b0, s);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      model_reset();
      exp_frames = 0;
      check_reset_outputs("t6_reset_mid_word");
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(32'h6100_0000 + i, 1'b1 & (i == 3), s);
      void'(exp_q.pop_back());
      bus.fifo_full = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      model_reset();
      exp_frames = 0;
      check_reset_outputs("t6_reset_full");
      send_beat(32'h6200_0000, 1'b1, s);
      idle(2);
      check_frames("t6_frame_cnt_after");
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_full_stall();
      test_clear();
      test_back_to_back();
      test_reset_mid();
      idle(3);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d words never written, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
